jk_cmd_seq: RTL and testbench
=============================

JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning command FIFO depth in entries (power of two, 2..16).
REQ-002 The module SHALL have parameter GAP, default 0, meaning idle cycles forced between consecutive issued commands (0..15).
REQ-003 The module SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rstn  input  1  meaning asynchronous reset, active low.
REQ-005 The module SHALL have port cmd_valid  input  1  meaning a command is offered on cmd_op.
REQ-006 The module SHALL have port cmd_op  input  2  meaning the operation: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-007 The module SHALL have port cmd_ready  output  1  meaning the FIFO can accept a command this cycle.
REQ-008 The module SHALL have ports J and K  output  1 each  meaning registered drive to the downstream JK flip-flop.
REQ-009 The module SHALL have port q_in  input  1  meaning the Q output fed back from the downstream JK flip-flop.
REQ-010 The module SHALL have port busy  output  1  meaning the FIFO is non-empty or the sequencer is not IDLE.
REQ-011 The module SHALL have port err  output  1  meaning sticky Q-mismatch flag (see Configuration).

Function
REQ-012 A command SHALL be accepted exactly on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 iff the FIFO is not full.
REQ-013 When full, cmd_ready SHALL be 0 even if a pop occurs in the same cycle; no overwrite, no loss.
REQ-014 The sequencer SHALL be a 3-state FSM: IDLE, ISSUE, WAIT.
REQ-015 IDLE -> ISSUE when the FIFO is non-empty; the head entry is popped on that edge and its op is registered onto J/K per REQ-006 encoding (hold: J=0,K=0; clear: 0,1; set: 1,0; toggle: 1,1).
REQ-016 ISSUE SHALL last exactly one cycle; J/K SHALL be 0/0 in every cycle not in ISSUE.
REQ-017 ISSUE -> WAIT if GAP>0, WAIT lasting exactly GAP cycles, then -> IDLE; ISSUE -> IDLE directly if GAP=0.
REQ-018 With GAP=0 and FIFO continuously non-empty, commands SHALL issue every second cycle (ISSUE, IDLE alternating).
REQ-019 Latency: a command accepted into an empty FIFO at edge N with FSM in IDLE SHALL drive J/K in the cycle after edge N+1.
REQ-020 Commands SHALL issue in acceptance order; FIFO pointers SHALL wrap modulo DEPTH with one extra bit distinguishing full from empty.
REQ-021 A hold op SHALL still consume an ISSUE slot and any WAIT.
REQ-022 A shadow register SHALL track expected Q: updated on each ISSUE per JK truth table (hold keeps, clear 0, set 1, toggle inverts).

Reset
REQ-023 rstn=0 SHALL asynchronously force: FIFO empty, FSM IDLE, J=0, K=0, shadow=0, err=0, busy=0, cmd_ready=1 on release.
REQ-024 Reset mid-operation (any state, any occupancy) SHALL discard all queued and in-flight commands; no J/K pulse follows release.

Configuration
REQ-025 Macro JK_CMD_SEQ_CHECK_EN SHALL, when defined, compare q_in against the shadow in the second cycle after each ISSUE cycle and set err=1 on mismatch, held until reset.
REQ-026 Without JK_CMD_SEQ_CHECK_EN, err SHALL be constant 0 and q_in SHALL be unused; all other behaviour identical.

Verification
REQ-027 Reset then push set (10) in one cycle -> J=1,K=0 for exactly one cycle two cycles later; busy drops after; Q=1 downstream.
REQ-028 DEPTH=4, GAP=0: push 6 back-to-back ops -> cmd_ready=0 after FIFO fills, exactly 6 J/K pulses in order, one every 2 cycles.
REQ-029 GAP=3: push two toggles -> J/K pulses separated by 4 idle cycles (WAIT 3 + IDLE 1); Q sequence 0->1->0.
REQ-030 Fill FIFO, assert rstn=0 for 1 cycle mid-stream -> J=K=0 immediately, no further pulses, cmd_ready=1 after release.
REQ-031 With JK_CMD_SEQ_CHECK_EN: issue set while forcing q_in=0 -> err=1 two cycles after ISSUE and remains 1; correct q_in keeps err=0.
REQ-032 Push during full with simultaneous pop -> command not accepted; total issued count equals accepted count.

Source files
------------

// File: rtl/jk_cmd_seq.sv
// Purpose: queues 2-bit JK commands in a FIFO and plays them out as one-cycle J/K pulses to a downstream JK flop.
// Latency: command accepted at edge N into an empty FIFO with the sequencer idle drives J/K in the cycle after edge N+1.
// Backpressure: cmd_ready is low whenever the FIFO is full, even if a pop happens that cycle. Optional Q check: JK_CMD_SEQ_CHECK_EN.
module jk_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       J,
    output logic       K,
    input  logic       q_in,
    output logic       busy,
    output logic       err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [3:0]  GAP_LOAD = 4'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [1:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [1:0]  head_op;

    state_t      state_q, state_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        j_q, j_d;
    logic        k_q, k_d;
    logic        shadow_q, shadow_d;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head_op    = mem_q[rd_ptr_q[AW-1:0]];

    assign J    = j_q;
    assign K    = k_q;
    assign busy = !fifo_empty || (state_q != S_IDLE);

    // FIFO storage: data needs no reset, validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= cmd_op;
        end
    end

    // FIFO pointers advance on push/pop and wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Sequencer state, registered J/K drive and expected-Q shadow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            shadow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            j_q       <= j_d;
            k_q       <= k_d;
            shadow_q  <= shadow_d;
        end
    end

    // Next state: pop on IDLE->ISSUE, J/K high only during ISSUE, WAIT counts GAP cycles.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        pop       = 1'b0;
        j_d       = 1'b0;
        k_d       = 1'b0;
        shadow_d  = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                    j_d     = head_op[1];
                    k_d     = head_op[0];
                    case (head_op)
                        2'b01:   shadow_d = 1'b0;
                        2'b10:   shadow_d = 1'b1;
                        2'b11:   shadow_d = !shadow_q;
                        default: shadow_d = shadow_q;
                    endcase
                end
            end
            S_ISSUE: begin
                if (GAP > 0) begin
                    state_d   = S_WAIT;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef JK_CMD_SEQ_CHECK_EN
    logic chk1_q;
    logic chk2_q;
    logic exp_q;
    logic err_q;

    // Expected Q is captured one cycle after ISSUE, before a following ISSUE can move
    // the shadow, then compared with q_in one cycle later; a mismatch sticks until reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chk1_q <= 1'b0;
            chk2_q <= 1'b0;
            exp_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            chk1_q <= (state_q == S_ISSUE);
            chk2_q <= chk1_q;
            if (chk1_q) exp_q <= shadow_q;
            if (chk2_q && (q_in != exp_q)) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_q_in;
    assign unused_q_in = q_in;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed bench for jk_cmd_seq: one DUT with GAP=0 and one with GAP=3, each feeding a JK flop model.
// Inputs change 1 time unit after the rising edge and outputs are sampled at that point.
// The Q-check path is exercised when JK_CMD_SEQ_CHECK_EN is defined for the build.
module tb_jk_cmd_seq;

    logic       clk;
    logic       rstn;
    logic       v0, v3;
    logic [1:0] op0, op3;
    logic       rdy0, rdy3;
    logic       j0, k0, j3, k3;
    logic       qin0, qin3;
    logic       busy0, busy3;
    logic       err0, err3;
    logic       q0m, q3m;
    logic       force_en, force_val;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc0 = 0;
    logic [1:0] p0_op[$];
    int         p0_cyc[$];
    int         p3_cyc[$];

    logic [1:0] seq8 [8] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    logic [6:0] exp_j3 = 7'b0100001; // bit c = expected J/K of dut3 after the c-th observed edge

    jk_cmd_seq #(.DEPTH(4), .GAP(0)) dut0 (
        .clk(clk), .rstn(rstn), .cmd_valid(v0), .cmd_op(op0), .cmd_ready(rdy0),
        .J(j0), .K(k0), .q_in(qin0), .busy(busy0), .err(err0)
    );

    jk_cmd_seq #(.DEPTH(4), .GAP(3)) dut3 (
        .clk(clk), .rstn(rstn), .cmd_valid(v3), .cmd_op(op3), .cmd_ready(rdy3),
        .J(j3), .K(k3), .q_in(qin3), .busy(busy3), .err(err3)
    );

    assign qin0 = force_en ? force_val : q0m;
    assign qin3 = q3m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream JK flop models.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q0m <= 1'b0;
            q3m <= 1'b0;
        end else begin
            case ({j0, k0})
                2'b01:   q0m <= 1'b0;
                2'b10:   q0m <= 1'b1;
                2'b11:   q0m <= ~q0m;
                default: q0m <= q0m;
            endcase
            case ({j3, k3})
                2'b01:   q3m <= 1'b0;
                2'b10:   q3m <= 1'b1;
                2'b11:   q3m <= ~q3m;
                default: q3m <= q3m;
            endcase
        end
    end

    // Pulse and acceptance logging, sampled on the edge (pre-update values).
    always @(posedge clk) begin
        if (j0 || k0) begin
            p0_op.push_back({j0, k0});
            p0_cyc.push_back(cyc);
        end
        if (j3 || k3) p3_cyc.push_back(cyc);
        if (v0 && rdy0) acc0++;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        rstn = 1'b0; v0 = 1'b0; op0 = 2'b00; v3 = 1'b0; op3 = 2'b00;
        force_en = 1'b0; force_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", rdy0, 1);
        check("rst_j", j0, 0);
        check("rst_k", k0, 0);
        check("rst_busy", busy0, 0);
        check("rst_err", err0, 0);
        rstn = 1'b1;
        tick();

        // Single set: J=1,K=0 in the cycle after the second edge.
        v0 = 1'b1; op0 = 2'b10;
        tick();
        v0 = 1'b0;
        check("set_lat_j", j0, 0);
        check("set_busy", busy0, 1);
        tick();
        check("set_j", j0, 1);
        check("set_k", k0, 0);
        tick();
        check("set_j_off", j0, 0);
        check("set_busy_off", busy0, 0);
        check("set_q", q0m, 1);

        // Hold consumes an ISSUE slot with no pulse; Q kept.
        v0 = 1'b1; op0 = 2'b00;
        tick();
        v0 = 1'b0;
        check("hold_busy1", busy0, 1);
        tick();
        check("hold_jk", {j0, k0}, 0);
        check("hold_busy2", busy0, 1);
        tick();
        check("hold_busy_off", busy0, 0);
        check("hold_q", q0m, 1);

        // Eight back-to-back ops: FIFO fills, push while full with pop is refused.
        p0_op.delete(); p0_cyc.delete(); acc0 = 0;
        for (int i = 0; i < 8; i++) begin
            v0 = 1'b1; op0 = seq8[i];
            w = 0;
            while (!rdy0 && w < 20) begin
                tick();
                w++;
            end
            if (i == 7) check("full_no_accept", acc0, 7);
            tick();
            if (i == 6) check("full_ready", rdy0, 0);
        end
        v0 = 1'b0;
        w = 0;
        while (busy0 && w < 40) begin
            tick();
            w++;
        end
        check("drain_done", busy0, 0);
        check("accepted", acc0, 8);
        check("issued", p0_op.size(), 8);
        for (int i = 0; i < 8 && i < p0_op.size(); i++) begin
            check($sformatf("order%0d", i), p0_op[i], seq8[i]);
            if (i > 0) check($sformatf("spacing%0d", i), p0_cyc[i] - p0_cyc[i-1], 2);
        end

        // GAP=3: two toggles separated by 4 idle cycles; Q 0->1->0.
        p3_cyc.delete();
        v3 = 1'b1; op3 = 2'b11;
        tick();
        tick();
        v3 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            check($sformatf("gap_j%0d", c), j3, exp_j3[c]);
            check($sformatf("gap_k%0d", c), k3, exp_j3[c]);
            check($sformatf("gap_q%0d", c), q3m, (c >= 1 && c <= 5) ? 1 : 0);
            tick();
        end
        w = 0;
        while (busy3 && w < 20) begin
            tick();
            w++;
        end
        check("gap_drain", busy3, 0);
        check("gap_pulses", p3_cyc.size(), 2);
        if (p3_cyc.size() == 2) check("gap_spacing", p3_cyc[1] - p3_cyc[0], 5);

        // Reset mid-stream while a pulse is on J/K with commands queued.
        v0 = 1'b1; op0 = 2'b10;
        tick();
        op0 = 2'b01;
        tick();
        op0 = 2'b11;
        check("pre_rst_j", j0, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_j", j0, 0);
        check("mid_rst_k", k0, 0);
        check("mid_rst_busy", busy0, 0);
        v0 = 1'b0;
        @(posedge clk);
        #3;
        rstn = 1'b1;
        p0_op.delete(); p0_cyc.delete();
        tick();
        check("post_rst_ready", rdy0, 1);
        repeat (10) tick();
        check("post_rst_pulses", p0_op.size(), 0);
        check("post_rst_busy", busy0, 0);

`ifdef JK_CMD_SEQ_CHECK_EN
        // Correct Q feedback keeps err low.
        v0 = 1'b1; op0 = 2'b10;
        tick();
        v0 = 1'b0;
        repeat (6) tick();
        check("chk_ok_err", err0, 0);
        // Forced wrong Q after a set raises err, which then sticks.
        force_en = 1'b1; force_val = 1'b0;
        v0 = 1'b1; op0 = 2'b10;
        tick();
        v0 = 1'b0;
        repeat (5) tick();
        check("chk_bad_err", err0, 1);
        force_en = 1'b0;
        repeat (5) tick();
        check("chk_sticky", err0, 1);
`else
        // Without the check, err stays 0 even with wrong Q feedback.
        force_en = 1'b1; force_val = 1'b0;
        v0 = 1'b1; op0 = 2'b10;
        tick();
        v0 = 1'b0;
        repeat (6) tick();
        check("nochk_err", err0, 0);
        force_en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
